// File: rtl/final_nios2_ocimem_pkg.sv
// Shared types and jdo field positions for the OCI monitor-RAM arbiter.
package final_nios2_ocimem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        CPU  = 1'b0,
        JTAG = 1'b1
    } req_t;

    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_WDATA_LSB = 3;
    localparam int JDO_RDREQ_BIT = 35;

endpackage

// File: rtl/final_nios2_ocimem_arbiter_jtag_cmd.sv
// Single-entry JTAG command holder: pending flag, opcode, write data,
// the MonAReg address pointer with post-access increment, and overrun tracking.
module final_nios2_ocimem_jtag_cmd #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              set_addr,
    input  logic              wr_strobe,
    input  logic              rd_strobe,
    input  logic [37:0]       jdo,
    input  logic              done,
    output logic              pending,
    output logic              is_write,
    output logic [DATA_W-1:0] wdata,
    output logic [ADDR_W-1:0] areg,
    output logic              overrun
);
    import final_nios2_ocimem_pkg::*;

    logic              pending_reg, pending_next;
    logic              is_write_reg, is_write_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [ADDR_W-1:0] areg_reg, areg_next;
    logic              overrun_reg, overrun_next;
    logic              busy_after;
    logic              unused_jdo_bits;

    assign unused_jdo_bits = ^{jdo[37:36], jdo[2:0]};

    // A command retiring this cycle frees the slot for a strobe in the same cycle.
    assign busy_after = pending_reg && !done;

    always_comb begin
        pending_next  = pending_reg;
        is_write_next = is_write_reg;
        wdata_next    = wdata_reg;
        areg_next     = areg_reg;
        overrun_next  = overrun_reg;
        if (done) begin
            pending_next = 1'b0;
            areg_next    = areg_reg + 1'b1;
        end
        if (set_addr || wr_strobe || rd_strobe) begin
            if (busy_after) begin
                overrun_next = 1'b1;
            end else if (set_addr) begin
                areg_next = jdo[JDO_ADDR_LSB +: ADDR_W];
                if (jdo[JDO_RDREQ_BIT]) begin
                    pending_next  = 1'b1;
                    is_write_next = 1'b0;
                end
            end else if (wr_strobe) begin
                pending_next  = 1'b1;
                is_write_next = 1'b1;
                wdata_next    = jdo[JDO_WDATA_LSB +: DATA_W];
            end else begin
                pending_next  = 1'b1;
                is_write_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending_reg  <= 1'b0;
            is_write_reg <= 1'b0;
            wdata_reg    <= '0;
            areg_reg     <= '0;
            overrun_reg  <= 1'b0;
        end else begin
            pending_reg  <= pending_next;
            is_write_reg <= is_write_next;
            wdata_reg    <= wdata_next;
            areg_reg     <= areg_next;
            overrun_reg  <= overrun_next;
        end
    end

    assign pending  = pending_reg;
    assign is_write = is_write_reg;
    assign wdata    = wdata_reg;
    assign areg     = areg_reg;
    assign overrun  = overrun_reg;

endmodule

// File: rtl/final_nios2_ocimem_arbiter.sv
// OCI monitor-RAM arbiter: CPU debug slave vs JTAG commands, IDLE/ACCESS/RESP pipeline.
// Define FINAL_NIOS2_OCIMEM_ROUND_ROBIN_EN for round-robin; otherwise JTAG has fixed priority.
module final_nios2_ocimem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [37:0]       jdo,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [DATA_W-1:0] cpu_writedata,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic              cpu_waitrequest,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              jtag_busy,
    output logic              jtag_overrun
);
    import final_nios2_ocimem_pkg::*;

    state_t            state_reg, state_next;
    req_t              grant_reg, grant_next;
    logic [ADDR_W-1:0] ram_address_reg, ram_address_next;
    logic              ram_wren_reg, ram_wren_next;
    logic [DATA_W-1:0] ram_wdata_reg, ram_wdata_next;
    logic [DATA_W-1:0] mon_dreg_reg, mon_dreg_next;

    logic              cpu_req, jtag_first, pick_jtag, jtag_done, cpu_done;
    logic              jtag_pending, jtag_is_write;
    logic [DATA_W-1:0] jtag_wdata;
    logic [ADDR_W-1:0] mon_areg;

    assign cpu_req   = cpu_read | cpu_write;
    assign jtag_done = (state_reg == RESP) && (grant_reg == JTAG);
    assign cpu_done  = (state_reg == RESP) && (grant_reg == CPU);

`ifdef FINAL_NIOS2_OCIMEM_ROUND_ROBIN_EN
    // Records the winner of the last contested grant so contests alternate.
    req_t last_grant_reg, last_grant_next;
    assign jtag_first = (last_grant_reg == CPU);
`else
    assign jtag_first = 1'b1;
`endif

    assign pick_jtag = jtag_pending && (!cpu_req || jtag_first);

    final_nios2_ocimem_jtag_cmd #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_jtag_cmd (
        .clk       (clk),
        .reset_n   (reset_n),
        .set_addr  (take_action_ocimem_a),
        .wr_strobe (take_action_ocimem_b),
        .rd_strobe (take_no_action_ocimem_a),
        .jdo       (jdo),
        .done      (jtag_done),
        .pending   (jtag_pending),
        .is_write  (jtag_is_write),
        .wdata     (jtag_wdata),
        .areg      (mon_areg),
        .overrun   (jtag_overrun)
    );

    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        ram_address_next = ram_address_reg;
        ram_wren_next    = 1'b0;
        ram_wdata_next   = ram_wdata_reg;
        mon_dreg_next    = mon_dreg_reg;
`ifdef FINAL_NIOS2_OCIMEM_ROUND_ROBIN_EN
        last_grant_next  = last_grant_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (jtag_pending || cpu_req) begin
                    state_next = ACCESS;
`ifdef FINAL_NIOS2_OCIMEM_ROUND_ROBIN_EN
                    if (jtag_pending && cpu_req)
                        last_grant_next = pick_jtag ? JTAG : CPU;
`endif
                    if (pick_jtag) begin
                        grant_next       = JTAG;
                        ram_address_next = mon_areg;
                        ram_wren_next    = jtag_is_write;
                        ram_wdata_next   = jtag_wdata;
                    end else begin
                        // Read and write together is serviced as a write.
                        grant_next       = CPU;
                        ram_address_next = cpu_address;
                        ram_wren_next    = cpu_write;
                        ram_wdata_next   = cpu_writedata;
                    end
                end
            end
            ACCESS: state_next = RESP;
            RESP: begin
                state_next = IDLE;
                if (jtag_done && !jtag_is_write)
                    mon_dreg_next = ram_rdata;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            grant_reg       <= CPU;
            ram_address_reg <= '0;
            ram_wren_reg    <= 1'b0;
            ram_wdata_reg   <= '0;
            mon_dreg_reg    <= '0;
`ifdef FINAL_NIOS2_OCIMEM_ROUND_ROBIN_EN
            last_grant_reg  <= CPU;
`endif
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            ram_address_reg <= ram_address_next;
            ram_wren_reg    <= ram_wren_next;
            ram_wdata_reg   <= ram_wdata_next;
            mon_dreg_reg    <= mon_dreg_next;
`ifdef FINAL_NIOS2_OCIMEM_ROUND_ROBIN_EN
            last_grant_reg  <= last_grant_next;
`endif
        end
    end

    assign cpu_waitrequest = !cpu_done;
    assign cpu_readdata    = cpu_done ? ram_rdata : '0;
    assign ram_address     = ram_address_reg;
    assign ram_wren        = ram_wren_reg;
    assign ram_wdata       = ram_wdata_reg;
    assign MonDReg         = mon_dreg_reg;
    assign MonAReg         = mon_areg;
    assign jtag_busy       = jtag_pending;

endmodule

// File: tb/tb_final_nios2_ocimem_arbiter.sv
// Directed bench for final_nios2_ocimem_arbiter with a behavioural RAM and a
// reference memory feeding an expected-value queue.
module tb_final_nios2_ocimem_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              take_action_ocimem_a = 1'b0;
    logic              take_action_ocimem_b = 1'b0;
    logic              take_no_action_ocimem_a = 1'b0;
    logic [37:0]       jdo = '0;
    logic [ADDR_W-1:0] cpu_address = '0;
    logic              cpu_read = 1'b0;
    logic              cpu_write = 1'b0;
    logic [DATA_W-1:0] cpu_writedata = '0;
    logic [DATA_W-1:0] cpu_readdata;
    logic              cpu_waitrequest;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;
    logic [DATA_W-1:0] MonDReg;
    logic [ADDR_W-1:0] MonAReg;
    logic              jtag_busy;
    logic              jtag_overrun;

    logic [31:0] mem    [256];
    logic [31:0] sb_mem [256];
    logic [31:0] exp_q  [$];
    logic [7:0]  areg_m;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    final_nios2_ocimem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .jdo                     (jdo),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_readdata            (cpu_readdata),
        .cpu_waitrequest         (cpu_waitrequest),
        .ram_address             (ram_address),
        .ram_wren                (ram_wren),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .jtag_busy               (jtag_busy),
        .jtag_overrun            (jtag_overrun)
    );

    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_wdata;
        ram_rdata <= mem[ram_address];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] jdo_setaddr(input logic [7:0] a, input logic rd);
        logic [37:0] p;
        p = '0;
        p[24:17] = a;
        p[35] = rd;
        return p;
    endfunction

    function automatic logic [37:0] jdo_write(input logic [31:0] d);
        logic [37:0] p;
        p = '0;
        p[34:3] = d;
        return p;
    endfunction

    // kind: 0 set-address, 1 write, 2 read; returns one cycle after the strobe.
    task automatic jtag_cmd(input int kind, input logic [37:0] payload);
        jdo = payload;
        take_action_ocimem_a    = (kind == 0);
        take_action_ocimem_b    = (kind == 1);
        take_no_action_ocimem_a = (kind == 2);
        tick();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic wait_jtag_idle(output int cycles);
        cycles = 0;
        while (jtag_busy && cycles < 50) begin
            tick();
            cycles++;
        end
    endtask

    task automatic cpu_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                            input int exp_lat, input string tag);
        int lat;
        cpu_address   = addr;
        cpu_writedata = data;
        cpu_write     = wr;
        cpu_read      = !wr;
        if (wr) sb_mem[addr] = data;
        else    exp_q.push_back(sb_mem[addr]);
        lat = 0;
        while (cpu_waitrequest && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        if (!wr) check({tag, "_rdata"}, cpu_readdata, exp_q.pop_front());
        $display("cpu %s addr=0x%02h data=0x%08h latency=%0d", wr ? "wr" : "rd", addr,
                 wr ? data : cpu_readdata, lat);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        tick();
    endtask

    initial begin
        int cyc;
        int lat;
        logic exp_j;

        for (int i = 0; i < 256; i++) begin
            mem[i]    = {i[7:0], ~i[7:0], i[7:0] ^ 8'h5A, 8'hC3};
            sb_mem[i] = {i[7:0], ~i[7:0], i[7:0] ^ 8'h5A, 8'hC3};
        end

        // Reset values
        reset_n = 1'b0;
        repeat (3) tick();
        check("rst_waitrequest", cpu_waitrequest, 1);
        check("rst_readdata", cpu_readdata, 0);
        check("rst_ram_address", ram_address, 0);
        check("rst_ram_wren", ram_wren, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_MonDReg", MonDReg, 0);
        check("rst_MonAReg", MonAReg, 0);
        check("rst_jtag_busy", jtag_busy, 0);
        check("rst_jtag_overrun", jtag_overrun, 0);
        reset_n = 1'b1;
        tick();
        $display("reset released");

        // CPU round trip
        cpu_xfer(1'b1, 8'h10, 32'hDEADBEEF, 2, "cpu_wr_10");
        cpu_xfer(1'b0, 8'h10, 32'h0, 2, "cpu_rd_10");

        // JTAG set-address with read, then write with wrap
        jtag_cmd(0, jdo_setaddr(8'hFE, 1'b1));
        areg_m = 8'hFE;
        exp_q.push_back(sb_mem[areg_m]);
        check("jtag_busy_n1", jtag_busy, 1);
        wait_jtag_idle(cyc);
        check("jtag_busy_cycles", cyc, 3);
        check("jtag_rd_fe", MonDReg, exp_q.pop_front());
        areg_m = areg_m + 8'd1;
        check("jtag_areg_ff", MonAReg, areg_m);
        $display("jtag rd addr=0xfe MonDReg=0x%08h MonAReg=0x%02h", MonDReg, MonAReg);

        jtag_cmd(1, jdo_write(32'h1234));
        sb_mem[areg_m] = 32'h1234;
        areg_m = areg_m + 8'd1;
        wait_jtag_idle(cyc);
        check("jtag_areg_wrap", MonAReg, areg_m);
        $display("jtag wr data=0x00001234 MonAReg=0x%02h", MonAReg);
        cpu_xfer(1'b0, 8'hFF, 32'h0, 2, "cpu_rd_ff");

        // Strobe landing in the RESP cycle of the previous command
        jtag_cmd(0, jdo_setaddr(8'h20, 1'b0));
        areg_m = 8'h20;
        check("setaddr_only_busy", jtag_busy, 0);
        check("setaddr_only_areg", MonAReg, areg_m);
        jtag_cmd(2, '0);
        exp_q.push_back(sb_mem[areg_m]);
        areg_m = areg_m + 8'd1;
        tick();
        tick();
        jtag_cmd(2, '0);
        exp_q.push_back(sb_mem[areg_m]);
        areg_m = areg_m + 8'd1;
        check("edge_busy", jtag_busy, 1);
        check("edge_overrun", jtag_overrun, 0);
        check("edge_rd_first", MonDReg, exp_q.pop_front());
        wait_jtag_idle(cyc);
        check("edge_rd_second", MonDReg, exp_q.pop_front());
        check("edge_areg", MonAReg, areg_m);
        $display("jtag back-to-back rd MonDReg=0x%08h MonAReg=0x%02h", MonDReg, MonAReg);

        // Overrun: second read one cycle later is dropped
        jtag_cmd(2, '0);
        exp_q.push_back(sb_mem[areg_m]);
        areg_m = areg_m + 8'd1;
        tick();
        jtag_cmd(2, '0);
        check("ovr_set", jtag_overrun, 1);
        wait_jtag_idle(cyc);
        check("ovr_rd", MonDReg, exp_q.pop_front());
        check("ovr_areg", MonAReg, areg_m);
        repeat (3) tick();
        check("ovr_sticky", jtag_overrun, 1);
        $display("jtag overrun=%0d MonAReg=0x%02h", jtag_overrun, MonAReg);

        // Contention; reset first so the arbiter history is known
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check("ovr_cleared", jtag_overrun, 0);
        areg_m = 8'h00;
        for (int k = 0; k < 4; k++) begin
            jtag_cmd(1, jdo_write(32'hC0DE0000 + 32'(k)));
            cpu_address = 8'h10;
            cpu_read    = 1'b1;
            exp_q.push_back(sb_mem[8'h10]);
`ifdef FINAL_NIOS2_OCIMEM_ROUND_ROBIN_EN
            exp_j = (k % 2 == 0);
`else
            exp_j = 1'b1;
`endif
            tick();
            check("cont_grant_jtag", ram_wren, exp_j);
            lat = 1;
            while (cpu_waitrequest && lat < 20) begin
                tick();
                lat++;
            end
            check("cont_cpu_latency", lat, exp_j ? 5 : 2);
            check("cont_cpu_rdata", cpu_readdata, exp_q.pop_front());
            $display("contest %0d first=%s cpu_latency=%0d", k, exp_j ? "jtag" : "cpu", lat);
            cpu_read = 1'b0;
            sb_mem[areg_m] = 32'hC0DE0000 + 32'(k);
            areg_m = areg_m + 8'd1;
            wait_jtag_idle(cyc);
            tick();
        end
        check("cont_areg", MonAReg, areg_m);
        cpu_xfer(1'b0, 8'h02, 32'h0, 2, "cpu_rd_jtagwr");

        // Reset in the ACCESS cycle of a JTAG write
        jtag_cmd(1, jdo_write(32'h55));
        tick();
        check("mid_wren_access", ram_wren, 1);
        sb_mem[areg_m] = 32'h55;
        reset_n = 1'b0;
        tick();
        check("mid_rst_wren", ram_wren, 0);
        check("mid_rst_busy", jtag_busy, 0);
        check("mid_rst_waitrequest", cpu_waitrequest, 1);
        check("mid_rst_address", ram_address, 0);
        check("mid_rst_MonAReg", MonAReg, 0);
        reset_n = 1'b1;
        tick();
        $display("reset mid-write busy=%0d wren=%0d", jtag_busy, ram_wren);
        cpu_xfer(1'b0, 8'h10, 32'h0, 2, "cpu_rd_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
